data_mem_responder: RTL and testbench

//  Responder for the CPU data-memory port: serves memwrite/addr/writedata and returns readdata.

---
 rtl/data_mem_responder_pkg.sv | 29 ++
 rtl/data_mem_responder_tx_fifo.sv | 77 +++++++
 rtl/data_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module : data_mem_responder_pkg
//  Purpose: Shared memory-map constants for the CPU data-memory responder.
//           - Register selects within the MMIO page (TXDATA/STATUS/CYCLE/LEDS).
//           - STATUS bit positions.
//           - Default MMIO page base.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

  // Register select (addr[3:2]) within the 16-byte MMIO page
  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_LEDS   = 2'd3
  } mmio_reg_e;

  // STATUS register bit positions
  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

endpackage : data_mem_responder_pkg
`default_nettype wire

// File: rtl/data_mem_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module : tx_fifo
//  Purpose: Synchronous FIFO for the console TX byte stream.
//           A push is accepted while full only when a pop happens in the same
//           cycle; the head entry is always presented on dout.
//  Ports  : clk, rst           clock, synchronous active-high reset
//           push, din          enqueue request and data
//           pop                dequeue request (ignored when empty)
//           dout               head entry
//           full, empty        occupancy flags
//  Rev    : 1.0  initial release
// ============================================================================
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == C_FULL_COUNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps modulo DEPTH
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule : tx_fifo
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module : data_mem_responder
//  Purpose: Responder for the CPU data-memory port. Word RAM plus a 16-byte
//           MMIO page holding a console TX FIFO, a free-running cycle counter
//           and an LED register. Reads are combinational from addr; writes
//           take effect on the clock edge where memwrite is high.
//  Config : DMEM_ALIGN_CHECK_EN - when defined, a write with addr[1:0]!=0 is
//           suppressed and sets the sticky fault flag; otherwise fault is 0
//           and the low address bits are ignored.
//  Ports  : clk, rst                 clock, synchronous active-high reset
//           memwrite, addr, writedata CPU store strobe / byte address / data
//           readdata                 load data (combinational)
//           tx_valid, tx_data, tx_ready  console byte stream out
//           leds                     LED register
//           fault                    sticky misaligned-write flag
//  Rev    : 1.0  initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [15:0] leds,
  output logic        fault
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic [31:0]   ram_q [RAM_DEPTH];
  logic [31:0]   cycle_q, cycle_d;
  logic [15:0]   leds_q,  leds_d;
  logic          ovf_q,   ovf_d;
  logic          fault_q, fault_d;

  logic          is_ram;
  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  mmio_reg_e     reg_sel;
  logic          wr_en;
  logic          misaligned;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   status_word;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign is_ram     = (addr[31:AW+2] == '0);
  assign is_mmio    = (addr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx    = addr[AW+1:2];
  assign reg_sel    = mmio_reg_e'(addr[3:2]);
  assign misaligned = |addr[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign wr_en = memwrite && !misaligned;
`else
  assign wr_en = memwrite;
`endif

  // --------------------------------------------------------------------------
  // Data RAM: asynchronous read, synchronous write, contents not reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) ram_q[ram_idx] <= writedata;
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  assign fifo_push = wr_en && is_mmio && (reg_sel == REG_TXDATA);
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (writedata[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // MMIO registers: CYCLE, LEDS, overflow and fault flags
  // --------------------------------------------------------------------------
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    leds_d  = leds_q;
    ovf_d   = ovf_q;
    fault_d = fault_q;

    if (wr_en && is_mmio) begin
      case (reg_sel)
        REG_CYCLE:  cycle_d = writedata;
        REG_LEDS:   leds_d  = writedata[15:0];
        REG_STATUS: if (writedata[STATUS_OVF_BIT]) ovf_d = 1'b0;
        default:    ;
      endcase
    end

    // Dropped byte: full and the head is not leaving this cycle. Setting
    // takes precedence over a simultaneous clear so no loss goes unseen.
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

`ifdef DMEM_ALIGN_CHECK_EN
    if (memwrite && misaligned) fault_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      leds_q  <= '0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      leds_q  <= leds_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
  end

  assign leds = leds_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign fault = fault_q;
`else
  // Flag is constant here; the AND only keeps the low address bits referenced.
  assign fault = fault_q & misaligned;
`endif

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    status_word                   = '0;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_OVF_BIT]   = ovf_q;
  end

  always_comb begin
    readdata = '0;
    if (is_ram) begin
      readdata = ram_q[ram_idx];
    end else if (is_mmio) begin
      case (reg_sel)
        REG_STATUS: readdata = status_word;
        REG_CYCLE:  readdata = cycle_q;
        REG_LEDS:   readdata = {16'h0000, leds_q};
        default:    readdata = '0;  // TXDATA is write-only
      endcase
    end
  end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module : tb_data_mem_responder
//  Purpose: Directed self-checking bench for data_mem_responder.
//           Covers RAM write/read, TX FIFO stream and overflow, CYCLE wrap,
//           LEDS, unmapped accesses, misaligned writes and mid-stream reset.
//  Config : DMEM_ALIGN_CHECK_EN selects the expected misaligned-write result.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] A_LEDS   = 32'hFFFF_000C;
  localparam int          DEPTH    = 8;

  logic        clk;
  logic        rst;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [15:0] leds;
  logic        fault;

  int n_checks;
  int n_errors;

  data_mem_responder #(
    .RAM_DEPTH  (1024),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .leds      (leds),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write one word; the store lands on the rising edge in between.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  // Combinational load: no clock edge needed.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    memwrite  = 1'b0;
    addr      = '0;
    writedata = '0;
    tx_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // ---- reset state
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_leds",     {16'b0, leds},     32'h0);
    check("rst_fault",    {31'b0, fault},    32'h0);
    rd("rst_status", A_STATUS, 32'h2);
    rd("rst_cycle",  A_CYCLE,  32'h0);

    // ---- 1: RAM write / read
    wr(32'h14, 32'h0123_4567);
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd("ram_14", 32'h14, 32'h0123_4567);

    // ---- 2: two bytes out through the stream
    wr(A_TXDATA, 32'h41);
    wr(A_TXDATA, 32'h42);
    #1;
    check("tx_valid_held", {31'b0, tx_valid}, 32'h1);
    check("tx_data_held",  {24'b0, tx_data},  32'h41);
    @(negedge clk);
    check("tx_data_stable", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    #1;
    check("tx_byte0", {24'b0, tx_data}, 32'h41);
    @(negedge clk);
    check("tx_byte1", {24'b0, tx_data}, 32'h42);
    check("tx_valid1", {31'b0, tx_valid}, 32'h1);
    @(negedge clk);
    check("tx_drained", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd("status_empty", A_STATUS, 32'h2);

    // ---- 3: overflow, clear, full push+pop
    for (int i = 0; i <= DEPTH; i++) wr(A_TXDATA, 32'h10 + i);
    rd("status_ovf", A_STATUS, 32'h5);
    wr(A_STATUS, 32'h4);
    rd("status_ovf_clr", A_STATUS, 32'h1);
    check("head_before_pp", {24'b0, tx_data}, 32'h10);
    @(negedge clk);
    memwrite  = 1'b1;
    addr      = A_TXDATA;
    writedata = 32'h99;
    tx_ready  = 1'b1;
    @(negedge clk);
    memwrite  = 1'b0;
    tx_ready  = 1'b0;
    rd("status_pp_full", A_STATUS, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == DEPTH - 1) ? 8'h99 : 8'(8'h11 + i);
      #1;
      check($sformatf("drain%0d", i), {24'b0, tx_data}, {24'b0, exp_b});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    rd("status_drained", A_STATUS, 32'h2);

    // ---- 4: CYCLE load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
    @(negedge clk);
    rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("cycle_wrap", A_CYCLE, 32'h0);

    // ---- 5: LEDS and unmapped
    wr(A_LEDS, 32'h1234_ABCD);
    check("leds_out", {16'b0, leds}, 32'h0000_ABCD);
    rd("leds_rd", A_LEDS, 32'h0000_ABCD);
    rd("unmapped_rd", 32'h8000_0000, 32'h0);
    wr(32'h8000_0000, 32'h5555_5555);
    rd("unmapped_rd2", 32'h8000_0000, 32'h0);
    check("unmapped_leds", {16'b0, leds}, 32'h0000_ABCD);
    rd("unmapped_ram", 32'h10, 32'hDEAD_BEEF);
    rd("unmapped_status", A_STATUS, 32'h2);

    // ---- misaligned read goes to the aligned word, never faults
    rd("misalign_rd", 32'h11, 32'hDEAD_BEEF);
    check("misalign_rd_fault", {31'b0, fault}, 32'h0);

    // ---- 6: misaligned write
    wr(32'h12, 32'h1111_2222);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misalign_fault", {31'b0, fault}, 32'h1);
    rd("misalign_word", 32'h10, 32'hDEAD_BEEF);
`else
    check("misalign_fault", {31'b0, fault}, 32'h0);
    rd("misalign_word", 32'h10, 32'h1111_2222);
`endif

    // ---- reset mid-transmit
    wr(A_TXDATA, 32'h61);
    wr(A_TXDATA, 32'h62);
    wr(A_TXDATA, 32'h63);
    tx_ready = 1'b1;
    #1;
    check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_mid_fault", {31'b0, fault},    32'h0);
    rst      = 1'b0;
    tx_ready = 1'b0;
    rd("rst_mid_status", A_STATUS, 32'h2);
    check("rst_mid_leds", {16'b0, leds}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_data_mem_responder
`default_nettype wire
